multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 109 ++++++++++
 tb/tb_multiplier.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Sequential shift-add unsigned multiplier: one multiplier bit per cycle, LSB first,
// fixed WIDTH-cycle latency from start acceptance to the done pulse.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | iterating, one multiplier bit per cycle (exactly WIDTH cycles)
// DONE   | product just loaded, done pulse; start here chains a new operation
module multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   a_sh;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_sum;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]   cnt;
    logic            cnt_tc;
    logic            load;
    logic            step;
    logic            finish;

    // a_sh already carries the multiplicand shifted by the current bit index
    assign acc_sum = acc + (b_sh[0] ? a_sh : '0);
    assign cnt_tc  = (cnt == '0);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                step = 1'b1;
                if (cnt_tc) begin
                    finish    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == S_RUN);
            done  <= (state_nxt == S_DONE);
            if (load) begin
                a_sh <= {{WIDTH{1'b0}}, multiplicand};
                b_sh <= multiplier_in;
                acc  <= '0;
                cnt  <= CW'(WIDTH - 1);
            end else if (step) begin
                acc  <= acc_sum;
                a_sh <= a_sh << 1;
                b_sh <= b_sh >> 1;
                cnt  <= cnt - CW'(1);
            end
            // product only moves on completion, so the old result stays valid through RUN
            if (finish) begin
                product <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_multiplier.sv
// Directed checks of the shift-add multiplier at WIDTH=4 (incl. exhaustive sweep)
// and WIDTH=8.
module tb_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  product4;
    logic        busy4;
    logic        done4;
    logic        start8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] product8;
    logic        busy8;
    logic        done8;

    int errors = 0;
    int checks = 0;
    logic [7:0] last_prod4 = '0;

    multiplier #(.WIDTH(4)) dut4 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start4),
        .multiplicand  (a4),
        .multiplier_in (b4),
        .product       (product4),
        .busy          (busy4),
        .done          (done4)
    );

    multiplier #(.WIDTH(8)) dut8 (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start8),
        .multiplicand  (a8),
        .multiplier_in (b8),
        .product       (product8),
        .busy          (busy8),
        .done          (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts an operation, scrambles the operand inputs after capture, then counts
    // busy cycles up to done and checks the result.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input string tag);
        int nb;
        logic [7:0] exp;
        exp = {4'b0, a} * {4'b0, b};
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        a4 = ~a;
        b4 = ~b;
        nb = 0;
        while (busy4 && nb < 20) begin
            check({tag, " hold"}, {24'b0, product4}, {24'b0, last_prod4});
            check({tag, " busy&done"}, {31'b0, done4}, 32'd0);
            nb++;
            tick();
        end
        check({tag, " busy cycles"}, nb, 32'd4);
        check({tag, " done"}, {31'b0, done4}, 32'd1);
        check({tag, " product"}, {24'b0, product4}, {24'b0, exp});
        last_prod4 = exp;
        tick();
        check({tag, " done pulse width"}, {31'b0, done4}, 32'd0);
    endtask

    initial begin
        int nb;
        rst_n  = 1'b0;
        start4 = 1'b0;
        start8 = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        #12;
        check("reset product", {24'b0, product4}, 32'd0);
        check("reset busy", {31'b0, busy4}, 32'd0);
        check("reset done", {31'b0, done4}, 32'd0);
        tick();
        tick();

        // 15*15, start presented together with reset release: first edge must accept it
        rst_n  = 1'b1;
        a4 = 4'd15; b4 = 4'd15;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("first start busy", {31'b0, busy4}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("15x15 busy", {31'b0, busy4}, 32'd1);
        end
        tick();
        check("15x15 done", {31'b0, done4}, 32'd1);
        check("15x15 busy low", {31'b0, busy4}, 32'd0);
        check("15x15 product", {24'b0, product4}, 32'd225);
        tick();
        check("15x15 done drop", {31'b0, done4}, 32'd0);
        check("15x15 product hold", {24'b0, product4}, 32'd225);

        // back-to-back: 0*9 then 7*3 with start held in the DONE cycle
        a4 = 4'd0; b4 = 4'd9;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("0x9 busy last", {31'b0, busy4}, 32'd1);
        check("0x9 old product", {24'b0, product4}, 32'd225);
        tick();
        check("0x9 done", {31'b0, done4}, 32'd1);
        check("0x9 product", {24'b0, product4}, 32'd0);
        a4 = 4'd7; b4 = 4'd3;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("b2b busy", {31'b0, busy4}, 32'd1);
            check("b2b product held 0", {24'b0, product4}, 32'd0);
            tick();
        end
        check("7x3 done", {31'b0, done4}, 32'd1);
        check("7x3 product", {24'b0, product4}, 32'd21);
        tick();
        check("7x3 to idle", {31'b0, busy4}, 32'd0);

        // start and operand changes during RUN are ignored
        a4 = 4'd5; b4 = 4'd6;
        start4 = 1'b1;
        tick();
        a4 = 4'd1; b4 = 4'd1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        check("5x6 busy 4th", {31'b0, busy4}, 32'd1);
        tick();
        check("5x6 done", {31'b0, done4}, 32'd1);
        check("5x6 product", {24'b0, product4}, 32'd30);
        tick();
        check("5x6 no restart busy", {31'b0, busy4}, 32'd0);
        check("5x6 no second done", {31'b0, done4}, 32'd0);

        // reset on the 2nd busy cycle of 9*11
        a4 = 4'd9; b4 = 4'd11;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        check("9x11 busy before rst", {31'b0, busy4}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'b0, busy4}, 32'd0);
        check("abort done", {31'b0, done4}, 32'd0);
        check("abort product", {24'b0, product4}, 32'd0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done4 || busy4) nb++;
        end
        check("no activity after abort", nb, 32'd0);
        last_prod4 = '0;
        do_op4(4'd2, 4'd3, "2x3");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op4(4'(a), 4'(b), "sweep");
            end
        end

        // WIDTH=8: 255*255
        a8 = 8'd255; b8 = 8'd255;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        nb = 0;
        while (busy8 && nb < 40) begin
            nb++;
            tick();
        end
        check("w8 busy cycles", nb, 32'd8);
        check("w8 done", {31'b0, done8}, 32'd1);
        check("w8 product", {16'b0, product8}, 32'd65025);
        tick();
        check("w8 done drop", {31'b0, done8}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
